// File: rtl/mmio_bus_pkg.sv
// Shared types and constants for the MMIO bus controller and its window decoder.
package mmio_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
   localparam int          SEL_W    = 4;

endpackage

// File: rtl/mmio_bus_ctrl_decode.sv
// Window decoder: turns the 4-bit select field into a one-hot slave select,
// flagging windows that have no slave behind them.
module mmio_addr_decode
   import mmio_bus_pkg::*;
#(
   parameter int N_SLV = 4
) (
   input  logic [SEL_W-1:0] sel,
   output logic [N_SLV-1:0] onehot,
   output logic             invalid
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N_SLV; i++) begin
         onehot[i] = (int'(sel) == i);
      end
      invalid = (int'(sel) >= N_SLV);
   end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: CPU data port to N slave windows with wait-state
// handshaking, access timeout with error response and optional posted writes.
module mmio_bus_ctrl
   import mmio_bus_pkg::*;
#(
   parameter int N_SLV     = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int SEL_LSB   = 28,
   parameter int TIMEOUT   = 15,
   parameter int POSTED_WR = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [DATA_W-1:0]       cpu_wdata,
   output logic [DATA_W-1:0]       cpu_rdata,
   output logic                    cpu_ready,
   output logic                    cpu_err,
   output logic [N_SLV-1:0]        slv_sel,
   output logic                    slv_we,
   output logic [ADDR_W-1:0]       slv_addr,
   output logic [DATA_W-1:0]       slv_wdata,
   input  logic [N_SLV*DATA_W-1:0] slv_rdata,
   input  logic [N_SLV-1:0]        slv_ack
);

   localparam int              CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam bit              POSTED  = (POSTED_WR != 0);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                wr_pend, wr_pend_nxt;

   logic [N_SLV-1:0]    sel_nxt;
   logic                we_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   wdata_nxt;
   logic [DATA_W-1:0]   rdata_nxt;
   logic                ready_nxt;
   logic                err_nxt;

   logic [N_SLV-1:0]    dec_onehot;
   logic                dec_invalid;
   logic [DATA_W-1:0]   ack_rdata;
   logic                ack_hit;
   logic                timeout_hit;
   logic                post_this;

   mmio_addr_decode #(
      .N_SLV (N_SLV)
   ) u_decode (
      .sel     (cpu_addr[SEL_LSB +: SEL_W]),
      .onehot  (dec_onehot),
      .invalid (dec_invalid)
   );

   // Only the selected slave's ack and data matter; stray acks are masked off.
   always_comb begin
      ack_rdata = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (slv_sel[i]) begin
            ack_rdata = ack_rdata | slv_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ack_hit     = |(slv_ack & slv_sel);
   assign timeout_hit = (cnt == CNT_MAX);
   assign post_this   = POSTED && cpu_we;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      wr_pend_nxt = wr_pend;
      sel_nxt     = slv_sel;
      we_nxt      = slv_we;
      addr_nxt    = slv_addr;
      wdata_nxt   = slv_wdata;
      rdata_nxt   = cpu_rdata;
      ready_nxt   = 1'b0;
      err_nxt     = cpu_err;

      case (state)
         ST_IDLE: begin
            if (cpu_req) begin
               addr_nxt  = cpu_addr;
               wdata_nxt = cpu_wdata;
               err_nxt   = 1'b0;
               if (dec_invalid) begin
                  state_nxt = ST_ERR;
                  ready_nxt = 1'b1;
                  err_nxt   = 1'b1;
                  rdata_nxt = DATA_W'(ERR_WORD);
               end else begin
                  state_nxt   = ST_ACCESS;
                  sel_nxt     = dec_onehot;
                  we_nxt      = cpu_we;
                  cnt_nxt     = '0;
                  // A posted write is acknowledged to the CPU right away.
                  wr_pend_nxt = post_this;
                  ready_nxt   = post_this;
               end
            end
         end

         ST_ACCESS: begin
            if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + 1'b1;
            end
            if (ack_hit) begin
               if (!slv_we) begin
                  rdata_nxt = ack_rdata;
               end
               sel_nxt = '0;
               we_nxt  = 1'b0;
               if (wr_pend) begin
                  wr_pend_nxt = 1'b0;
                  state_nxt   = ST_IDLE;
               end else begin
                  state_nxt = ST_DONE;
                  ready_nxt = 1'b1;
               end
            end else if (timeout_hit) begin
               sel_nxt = '0;
               we_nxt  = 1'b0;
               err_nxt = 1'b1;
               // A timed-out posted write leaves cpu_err set as a sticky flag.
               if (wr_pend) begin
                  wr_pend_nxt = 1'b0;
                  state_nxt   = ST_IDLE;
               end else begin
                  rdata_nxt = DATA_W'(ERR_WORD);
                  state_nxt = ST_DONE;
                  ready_nxt = 1'b1;
               end
            end
         end

         ST_DONE, ST_ERR: begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b0;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         wr_pend   <= 1'b0;
         slv_sel   <= '0;
         slv_we    <= 1'b0;
         slv_addr  <= '0;
         slv_wdata <= '0;
         cpu_rdata <= '0;
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         wr_pend   <= wr_pend_nxt;
         slv_sel   <= sel_nxt;
         slv_we    <= we_nxt;
         slv_addr  <= addr_nxt;
         slv_wdata <= wdata_nxt;
         cpu_rdata <= rdata_nxt;
         cpu_ready <= ready_nxt;
         cpu_err   <= err_nxt;
      end
   end

endmodule
